// File: rtl/mulp_modmul_if.sv
// Operand/result bus between the core and the MULP modular multiplier.
interface mulp_modmul_if #(
    parameter int unsigned WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_m;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             range_err;

    modport master (
        output start, op_a, op_b, op_m,
        input  busy, done, result, range_err
    );

    modport slave (
        input  start, op_a, op_b, op_m,
        output busy, done, result, range_err
    );
endinterface

// File: rtl/mulp_modmul_unit.sv
// Bit-serial interleaved (a*b) mod m, one multiplier bit per cycle, MSB first.
// Optional operand range check enabled by defining MULP_RANGE_CHECK_EN.
module mulp_modmul_unit #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    mulp_modmul_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             range_err_q, range_err_d, range_hit_q, range_hit_d;

    logic [WIDTH:0]   dbl_c, t_c, sum_c;
    logic [WIDTH-1:0] u_c;
    logic             viol_c;

    // One interleaved step: acc' = (2*acc + b[cnt]*a) mod m using two conditional subtracts.
    always_comb begin
        dbl_c = {acc_q, 1'b0};
        t_c   = (dbl_c >= {1'b0, m_q}) ? (dbl_c - {1'b0, m_q}) : dbl_c;
        sum_c = t_c + {1'b0, a_q};
        if (b_q[cnt_q]) begin
            u_c = (sum_c >= {1'b0, m_q}) ? WIDTH'(sum_c - {1'b0, m_q}) : WIDTH'(sum_c);
        end else begin
            u_c = WIDTH'(t_c);
        end
    end

`ifdef MULP_RANGE_CHECK_EN
    assign viol_c = (bus.op_a >= bus.op_m) || (bus.op_b >= bus.op_m);
`else
    assign viol_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            range_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
            range_hit_q <= range_hit_d;
        end
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        range_err_d = range_err_q;
        range_hit_d = range_hit_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d         = bus.op_a;
                    b_d         = bus.op_b;
                    m_d         = bus.op_m;
                    acc_d       = '0;
                    cnt_d       = CNT_W'(WIDTH - 1);
                    busy_d      = 1'b1;
                    result_d    = '0;
                    range_err_d = 1'b0;
                    range_hit_d = viol_c;
                    state_d     = viol_c ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                acc_d = u_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Degenerate modulus and range violations both report zero.
                result_d    = (range_hit_q || (m_q < WIDTH'(2))) ? '0 : acc_q;
                range_err_d = range_hit_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_mulp_modmul_unit.sv
// Directed-vector bench for mulp_modmul_unit (WIDTH=256).
module tb_mulp_modmul_unit;

    localparam int unsigned W       = 256;
    localparam int unsigned FULL    = 257;
    localparam int unsigned TIMEOUT = 400;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mulp_modmul_if #(.WIDTH(W)) bus ();

    mulp_modmul_unit #(.WIDTH(W), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic [W-1:0] exp;
        bit           needs_rc;   // result only defined when the range check is built in
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit range_viol(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] m);
`ifdef MULP_RANGE_CHECK_EN
        return (a >= m) || (b >= m);
`else
        return 1'b0;
`endif
    endfunction

    // Issue one operation, optionally re-pulse start mid-run, then check timing and outputs.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input logic [W-1:0] exp, input bit chk_res,
                          input int repulse_at);
        int           lat;
        int           busy_n;
        bit           viol;
        int           exp_lat;
        logic [W-1:0] held;
        viol    = range_viol(a, b, m);
        exp_lat = viol ? 1 : FULL;
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.op_m  = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        lat    = 0;
        while (lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == repulse_at) begin
                bus.op_a  = '0;
                bus.op_b  = '0;
                bus.op_a[0] = 1'b1;
                bus.op_b[0] = 1'b1;
                bus.start = 1'b1;
            end else if (lat == repulse_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        check({name, " latency"}, W'(lat), W'(exp_lat));
        check({name, " busy cycles"}, W'(busy_n), W'(exp_lat));
        check({name, " busy low at done"}, W'(bus.busy), W'(0));
        check({name, " range_err"}, W'(bus.range_err), W'(viol));
        if (chk_res) check({name, " result"}, bus.result, exp);
        held = bus.result;
        @(posedge clk);
        #1;
        check({name, " done single pulse"}, W'(bus.done), W'(0));
        check({name, " result held"}, bus.result, held);
    endtask

    initial begin
        logic [W-1:0] p;
        logic [W-1:0] two128;
        p      = (W'(1) << 255) - W'(19);
        two128 = W'(1) << 128;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{"small 3*5 mod 7",   W'(3),     W'(5),    W'(7),       W'(1),      1'b0};
        vecs[1]  = '{"p-1 squared",       p - W'(1), p - W'(1), p,          W'(1),      1'b0};
        vecs[2]  = '{"zero times p-1",    W'(0),     p - W'(1), p,          W'(0),      1'b0};
        vecs[3]  = '{"2^128 squared",     two128,    two128,   p,           W'(38),     1'b0};
        vecs[4]  = '{"2 * 2^254",         W'(2),     W'(1) << 254, p,       W'(19),     1'b0};
        vecs[5]  = '{"(p-1)*2",           p - W'(1), W'(2),    p,           p - W'(2),  1'b0};
        vecs[6]  = '{"mid-size product",  W'(12345), W'(6789), W'(1000003), W'(809956), 1'b0};
        vecs[7]  = '{"b zero",            W'(5),     W'(0),    W'(13),      W'(0),      1'b0};
        vecs[8]  = '{"modulus one",       W'(5),     W'(6),    W'(1),       W'(0),      1'b0};
        vecs[9]  = '{"modulus zero",      W'(3),     W'(4),    W'(0),       W'(0),      1'b0};
        vecs[10] = '{"a out of range",    W'(9),     W'(2),    W'(7),       W'(0),      1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.op_m  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));
        check("reset result", bus.result, W'(0));
        check("reset range_err", W'(bus.range_err), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Consecutive vectors also exercise acceptance in the cycle after done.
        for (int i = 0; i < NVEC; i++) begin
`ifdef MULP_RANGE_CHECK_EN
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, 1'b1, -10);
`else
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp,
                   !vecs[i].needs_rc, -10);
`endif
        end

        // start re-pulsed at cycle 50 with different operands must be ignored.
        run_op("ignored restart", W'(3), W'(5), W'(7), W'(1), 1'b1, 50);
        run_op("back to back", W'(2), W'(3), W'(11), W'(6), 1'b1, -10);

        // Reset in the middle of a run.
        @(negedge clk);
        bus.op_a  = W'(3);
        bus.op_b  = W'(5);
        bus.op_m  = W'(7);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        check("busy before mid reset", W'(bus.busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("mid reset busy", W'(bus.busy), W'(0));
        check("mid reset done", W'(bus.done), W'(0));
        check("mid reset result", bus.result, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", W'(2), W'(3), W'(11), W'(6), 1'b1, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mulp_modmul_unit.md
Name: mulp_modmul_unit

Overview:
- Sequential 256-bit modular multiplier: result = (op_a * op_b) mod op_m.
- Execution engine for the MULP custom instruction; sits directly downstream of the core's 256-bit point register file.
- The core drives operands from two point registers and a modulus register, pulses start, stalls while busy, and writes result back to a point register on done.
- Bit-serial interleaved algorithm: one multiplier bit per cycle, MSB first.

Parameters:
- WIDTH, 256, operand/modulus/result width in bits.
- CNT_W, 8, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand; precondition op_a < op_m.
- op_b  input  WIDTH  multiplier; precondition op_b < op_m.
- op_m  input  WIDTH  modulus.
- busy  output  1  high from the edge after start is accepted until DONE is left.
- done  output  1  single-cycle pulse; result is valid.
- result  output  WIDTH  product mod op_m; held until the next accepted start.
- range_err  output  1  operand range violation flag; see Optional Feature.

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, result=0, range_err=0, internal acc/counter/latched operands=0.
- States:
  - IDLE: on start=1, latch op_a, op_b, op_m into internal regs; acc<=0, cnt<=WIDTH-1, busy<=1, result<=0, range_err<=0; go to RUN. With start=0, stay in IDLE.
  - RUN: each edge performs the two steps below, then cnt<=cnt-1. After processing cnt==0, go to DONE.
    1. t = 2*acc (WIDTH+1 bits); if t >= m, t = t - m.
    2. If b[cnt]: u = t + a (WIDTH+1 bits), and if u >= m, u = u - m; else u = t. acc <= u[WIDTH-1:0].
  - DONE (one cycle): result<=acc, done<=1 (registered, high this cycle only), busy<=0; go to IDLE.
- Latency: start sampled at edge E0; RUN occupies E1..E256; done and result are visible after E257. Total 257 cycles start-to-done for WIDTH=256.
- Throughput: the next start is accepted at the earliest in the cycle after done (IDLE).
- start while busy (RUN or DONE): ignored. Latched operands are unaffected by input changes after acceptance.
- Degenerate modulus: if latched m < 2, DONE forces result=0.
- Operands >= m without the optional feature: result is undefined, but the block must not hang; it still completes in 257 cycles.
- Reset mid-operation: immediate return to IDLE with all reset values; no done pulse.
- Width rules: all intermediates WIDTH+1 bits; one conditional subtract per step suffices given acc < m and a < m.

Optional Feature:
- Macro: MULP_RANGE_CHECK_EN.
- Defined: at acceptance, compare op_a >= op_m or op_b >= op_m. On violation, skip RUN, go straight to DONE next edge with result=0 and range_err=1 (held until next accepted start). Latency on violation is 1 cycle.
- Undefined: no comparators; range_err tied 0; all starts take the full 257-cycle path.

Test Plan:
- a=3, b=5, m=7, start one cycle -> busy high on cycles 1..257; done pulse exactly 257 cycles after start; result=1.
- m=2^255-19, a=b=m-1 -> result=1; a=0, b=m-1 -> result=0; a=2^128, b=2^128, m=2^255-19 -> result=38.
- Start with a=3, b=5, m=7; re-pulse start at cycle 50 with a=1, b=1 -> ignored; result=1 at cycle 257; back-to-back start in IDLE after done accepted.
- Assert rst_n=0 at cycle 100 of a run -> busy=0, done=0, result=0 immediately; then a=2, b=3, m=11 -> result=6 after 257 cycles.
- m=1 or m=0 with any a, b -> result=0 at done, no hang.
- With MULP_RANGE_CHECK_EN: a=9, b=2, m=7 -> done 1 cycle after start, result=0, range_err=1. Without the macro: range_err stays 0 and done arrives after 257 cycles.
